// File: rtl/shift_deserializer.sv
// Serial-in, parallel-out receiver: samples sdata on each tick and assembles an
// N-bit word MSB- or LSB-first. Optional even-parity bit via SHIFT_DESER_PARITY_EN.
module shift_deserializer #(
  parameter int unsigned N = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       tick,
  input  logic                       start,
  input  logic                       clear,
  input  logic                       dir,
  input  logic                       sdata,
  output logic [N-1:0]               data,
  output logic                       valid,
  output logic                       busy,
  output logic                       parity_err,
  output logic [$clog2(N+1)-1:0]     bit_cnt
);

  localparam int unsigned CW = $clog2(N+1);

`ifdef SHIFT_DESER_PARITY_EN
  typedef enum logic [1:0] {IDLE, SHIFT, PAR, DONE} state_t;
`else
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
`endif

  state_t         state, state_nxt;
  logic [N-1:0]   sreg, sreg_nxt;
  logic           dir_q;
  logic           last;

  assign last = (bit_cnt == CW'(N-1));

  always_comb begin
    sreg_nxt = dir_q ? {sdata, sreg[N-1:1]} : {sreg[N-2:0], sdata};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (clear) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:  if (start) state_nxt = SHIFT;
`ifdef SHIFT_DESER_PARITY_EN
        SHIFT: if (tick && last) state_nxt = PAR;
        PAR:   if (tick) state_nxt = DONE;
`else
        SHIFT: if (tick && last) state_nxt = DONE;
`endif
        DONE:  state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    valid = (state == DONE);
`ifdef SHIFT_DESER_PARITY_EN
    busy  = (state == SHIFT) || (state == PAR);
`else
    busy  = (state == SHIFT);
`endif
  end

  // data is loaded on the edge entering DONE so it is already current while valid is high
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sreg    <= '0;
      dir_q   <= 1'b0;
      bit_cnt <= '0;
      data    <= '0;
    end else if (clear) begin
      bit_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            dir_q   <= dir;
            sreg    <= '0;
            bit_cnt <= '0;
          end
        end
        SHIFT: begin
          if (tick) begin
            sreg    <= sreg_nxt;
            bit_cnt <= bit_cnt + CW'(1);
`ifndef SHIFT_DESER_PARITY_EN
            if (last) data <= sreg_nxt;
`endif
          end
        end
`ifdef SHIFT_DESER_PARITY_EN
        PAR: begin
          if (tick) data <= sreg;
        end
`endif
        default: ;
      endcase
    end
  end

`ifdef SHIFT_DESER_PARITY_EN
  logic par_acc;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      par_acc    <= 1'b0;
      parity_err <= 1'b0;
    end else if (!clear) begin
      case (state)
        IDLE:    if (start) par_acc <= 1'b0;
        SHIFT:   if (tick) par_acc <= par_acc ^ sdata;
        PAR:     if (tick) parity_err <= par_acc ^ sdata;
        default: ;
      endcase
    end
  end
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_shift_deserializer.sv
// Scoreboard bench for shift_deserializer (N=8): stimulus pushes expected words,
// a negedge monitor pops and compares whenever valid is seen.
module tb_shift_deserializer;

  localparam int unsigned N = 8;

  logic         clk = 1'b0;
  logic         reset, tick, start, clear, dir, sdata;
  logic [N-1:0] data;
  logic         valid, busy, parity_err;
  logic [3:0]   bit_cnt;

  int unsigned  tests = 0;
  int unsigned  fails = 0;
  int unsigned  pushed = 0;
  int unsigned  seen = 0;
  logic [N:0]   exp_q[$];

  shift_deserializer #(.N(N)) dut (
    .clk(clk), .reset(reset), .tick(tick), .start(start), .clear(clear),
    .dir(dir), .sdata(sdata), .data(data), .valid(valid), .busy(busy),
    .parity_err(parity_err), .bit_cnt(bit_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_word(input logic [N-1:0] d, input logic perr);
    exp_q.push_back({perr, d});
    pushed++;
  endtask

  // monitor: compare every valid strobe against the oldest expected word
  always @(negedge clk) begin
    if (!reset && valid) begin
      seen++;
      if (exp_q.size() == 0) begin
        chk("unexpected_valid", {23'd0, valid, data}, 32'd0);
      end else begin
        logic [N:0] e;
        e = exp_q.pop_front();
        chk("sb_data", {24'd0, data}, {24'd0, e[N-1:0]});
        chk("sb_parity_err", {31'd0, parity_err}, {31'd0, e[N]});
      end
    end
  end

  // seq[7] is the first bit on the wire
  task automatic run_frame(input logic [7:0] seq, input logic d, input logic toggle_dir,
                           input logic [7:0] exp_data, input logic pbit, input logic exp_perr);
    expect_word(exp_data, exp_perr);
    start = 1'b1; dir = d;
    cyc();
    start = 1'b0;
    chk("frame_busy_rise", {31'd0, busy}, 32'd1);
    chk("frame_cnt_start", {28'd0, bit_cnt}, 32'd0);
    for (int i = 0; i < 8; i++) begin
      tick = 1'b1; sdata = seq[7-i];
      cyc();
      tick = 1'b0;
      chk("frame_cnt", {28'd0, bit_cnt}, i + 1);
      if (i < 7) begin
        chk("frame_no_early_valid", {31'd0, valid}, 32'd0);
        if (toggle_dir && i == 3) dir = ~dir;
        cyc();
      end
    end
`ifdef SHIFT_DESER_EN_UNUSED
`endif
`ifdef SHIFT_DESER_PARITY_EN
    chk("par_no_valid_after_8", {31'd0, valid}, 32'd0);
    chk("par_busy_in_par", {31'd0, busy}, 32'd1);
    cyc();
    tick = 1'b1; sdata = pbit;
    cyc();
    tick = 1'b0;
`endif
    chk("frame_valid_pulse", {31'd0, valid}, 32'd1);
    chk("frame_busy_in_done", {31'd0, busy}, 32'd0);
    chk("frame_data", {24'd0, data}, {24'd0, exp_data});
    cyc();
    chk("frame_valid_one_cycle", {31'd0, valid}, 32'd0);
  endtask

  initial begin
    logic [7:0] s;
    reset = 1'b1; tick = 1'b0; start = 1'b1; clear = 1'b0; dir = 1'b1; sdata = 1'b1;
    #2;
    chk("rst_data", {24'd0, data}, 32'd0);
    chk("rst_valid", {31'd0, valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_perr", {31'd0, parity_err}, 32'd0);
    chk("rst_cnt", {28'd0, bit_cnt}, 32'd0);
    tick = 1'b1;
    cyc(); cyc();
    chk("rst_hold_busy", {31'd0, busy}, 32'd0);
    reset = 1'b0; start = 1'b0; tick = 1'b0; dir = 1'b0;
    cyc();

    // ticks with no start: nothing happens
    for (int i = 0; i < 6; i++) begin
      tick = (i % 2 == 0); sdata = 1'b1;
      cyc();
      chk("idle_tick_busy", {31'd0, busy}, 32'd0);
      chk("idle_tick_cnt", {28'd0, bit_cnt}, 32'd0);
    end
    tick = 1'b0;

    run_frame(8'b1011_0010, 1'b0, 1'b0, 8'hB2, 1'b0, 1'b0);
    run_frame(8'b1011_0010, 1'b1, 1'b1, 8'h4D, 1'b0, 1'b0);

    // start and tick together: tick is not a sample; start while busy ignored
    s = 8'h3C;
    expect_word(8'h3C, 1'b0);
    start = 1'b1; tick = 1'b1; sdata = 1'b1; dir = 1'b0;
    cyc();
    start = 1'b0; tick = 1'b0;
    chk("st_tick_busy", {31'd0, busy}, 32'd1);
    chk("st_tick_cnt", {28'd0, bit_cnt}, 32'd0);
    for (int i = 0; i < 8; i++) begin
      tick = 1'b1; sdata = s[7-i]; start = 1'b0;
      cyc();
      tick = 1'b0;
      chk("busy_start_cnt", {28'd0, bit_cnt}, i + 1);
      if (i < 7) begin
        start = 1'b1;
        cyc();
        chk("busy_start_still_busy", {31'd0, busy}, 32'd1);
      end
    end
`ifdef SHIFT_DESER_PARITY_EN
    cyc();
    tick = 1'b1; sdata = 1'b0;
    cyc();
    tick = 1'b0;
`endif
    chk("b2b_valid", {31'd0, valid}, 32'd1);
    start = 1'b1;
    cyc();
    chk("b2b_start_in_done_ignored", {31'd0, busy}, 32'd0);
    cyc();
    chk("b2b_start_after_done", {31'd0, busy}, 32'd1);
    start = 1'b0; clear = 1'b1;
    cyc();
    clear = 1'b0;
    chk("b2b_clear_busy", {31'd0, busy}, 32'd0);

    run_frame(8'b1011_0010, 1'b0, 1'b0, 8'hB2, 1'b0, 1'b0);

    // clear after 4 ticks; clear wins over a simultaneous tick
    start = 1'b1;
    cyc();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick = 1'b1; sdata = 1'b1;
      cyc();
      tick = 1'b0;
      cyc();
    end
    chk("clr_cnt_before", {28'd0, bit_cnt}, 32'd4);
    clear = 1'b1; tick = 1'b1;
    cyc();
    clear = 1'b0; tick = 1'b0;
    chk("clr_busy", {31'd0, busy}, 32'd0);
    chk("clr_cnt", {28'd0, bit_cnt}, 32'd0);
    chk("clr_data_kept", {24'd0, data}, 32'hB2);
    for (int i = 0; i < 10; i++) begin
      tick = 1'b1;
      cyc();
    end
    tick = 1'b0;
    chk("clr_idle_busy", {31'd0, busy}, 32'd0);

    // asynchronous reset mid-frame
    start = 1'b1;
    cyc();
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick = 1'b1; sdata = 1'b0;
      cyc();
      tick = 1'b0;
    end
    #1 reset = 1'b1;
    #1;
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_cnt", {28'd0, bit_cnt}, 32'd0);
    chk("arst_data", {24'd0, data}, 32'd0);
    #1 reset = 1'b0;
    cyc();

`ifdef SHIFT_DESER_PARITY_EN
    run_frame(8'b1011_0010, 1'b0, 1'b0, 8'hB2, 1'b0, 1'b0);
    run_frame(8'b1011_0010, 1'b0, 1'b0, 8'hB2, 1'b1, 1'b1);
    chk("perr_hold", {31'd0, parity_err}, 32'd1);
`endif

    run_frame(8'b1010_0101, 1'b1, 1'b0, 8'hA5, 1'b0, 1'b0);

    cyc(); cyc();
    chk("sb_drained", exp_q.size(), 32'd0);
    chk("valid_count", seen, pushed);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/shift_deserializer.md
# shift_deserializer

Serial-in, parallel-out receiver for the far end of the bidirectional shift-register link. It samples one serial bit per `tick` pulse, normally the 1 s `clockTick` output, and assembles N bits MSB-first or LSB-first. It presents the completed word with a one-cycle `valid` strobe. The block sits beside `shift_register` in board tests, where it reconstructs the word serialised out of the register's end bit and drives it to LEDs.

## Interface
- `N`, 8, data word width (≥2)
- `clk` input 1 system clock (CLOCK_50 domain)
- `reset` input 1 asynchronous, active-high; clears all state
- `tick` input 1 single-`clk` sample-enable pulse
- `start` input 1 begin a frame (level-sampled, any `clk` edge while idle)
- `clear` input 1 synchronous abort; returns to IDLE, no `valid`
- `dir` input 1 0 = MSB-first (shift left), 1 = LSB-first (shift right); latched at `start`
- `sdata` input 1 serial data, sampled when `tick`=1 in SHIFT/PAR
- `data` output N last completed word
- `valid` output 1 one-`clk` strobe: `data` just updated
- `busy` output 1 high in SHIFT or PAR
- `parity_err` output 1 qualified by `valid`; see Configuration
- `bit_cnt` output $clog2(N+1) bits captured in current frame (debug/LED)

## Operation
- States: IDLE, SHIFT, PAR (PAR exists only with the macro), DONE.
- IDLE: `start`=1 → SHIFT; latch `dir`; clear shift reg and `bit_cnt`. `tick` in the same cycle is not a data sample.
- SHIFT: on each `clk` edge with `tick`=1:
  - `dir`=0: sreg ← {sreg[N-2:0], sdata}.
  - `dir`=1: sreg ← {sdata, sreg[N-1:1]}.
  - `bit_cnt` increments.
  - The N-th sample moves to PAR when the macro is defined, otherwise to DONE.
- PAR: next `tick` samples the parity bit → DONE.
- DONE, one cycle: `data` ← sreg, `valid`=1 → IDLE.
- `start` while busy or in DONE is ignored.
- `clear`=1 in any state → IDLE next edge; `data` unchanged; `valid` stays 0; `clear` has priority over `tick`/`start`.
- `tick` in IDLE or DONE is ignored.
- `data` holds its value until the next DONE.

## Timing
- Reset values: `data`=0, `valid`=0, `busy`=0, `parity_err`=0, `bit_cnt`=0, state IDLE, shift reg 0, latched dir 0.
- `busy` rises on the edge after `start` is sampled.
- `valid` asserts on the `clk` edge after the final sampling tick (N-th data tick, or parity tick) and lasts exactly one `clk`. `busy` is 0 in that cycle.
- Back-to-back frames: `start` may be asserted in the cycle `valid`=1 (DONE). It is ignored. The earliest accepted `start` is the cycle after DONE.
- Minimum frame length in `clk` cycles: 1 (start) + N ticks (+1 parity tick) + 1 (DONE).
- `reset` mid-frame aborts immediately and asynchronously; no `valid` is produced.

## Configuration
- Macro `SHIFT_DESER_PARITY_EN`.
- Defined:
  - Frame = N data bits + 1 even-parity bit.
  - `parity_err` = XOR of all N+1 sampled bits, registered with `data` and valid with `valid`.
  - `parity_err` holds until the next DONE.
- Undefined:
  - No PAR state; frame = N bits.
  - `parity_err` is tied to 0.

## Test plan
- Reset in a random state, N=8: all outputs 0, `busy`=0. `tick` pulses with no `start` → `valid` never asserts.
- `dir`=0, bits 1,0,1,1,0,0,1,0 on 8 ticks (parity disabled) → `data`=8'hB2, one `valid` pulse one `clk` after the 8th tick.
- `dir`=1, same bit sequence → `data`=8'h4D. Toggling `dir` mid-frame has no effect.
- `start` and `tick` in the same IDLE cycle → that tick is not sampled; 8 further ticks are still required. `start` pulses while busy are ignored, and `bit_cnt` keeps counting.
- After 4 ticks, assert `clear` (also test `reset`) → IDLE, `bit_cnt`=0, no `valid`, `data` keeps the previous 8'hB2.
- With `SHIFT_DESER_PARITY_EN`:
  - 8'hB2 MSB-first then parity bit 0 → `valid`, `parity_err`=0.
  - Parity bit 1 → `parity_err`=1.
  - `valid` comes only after the 9th tick.
